// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants and shared sequencer types
package sha256_pkg;
  localparam int K_ROUNDS = 64;
  localparam int KBUF_DEPTH = 4;
  typedef enum logic {KSEQ_IDLE, KSEQ_STREAM} kseq_state_t;
  localparam logic [31:0] K_TABLE [K_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
endpackage

// File: rtl/block_rom.sv
// block_rom: synchronous-read ROM of the SHA-256 round constants, one cycle latency
module block_rom
  import sha256_pkg::*;
#(
  parameter int    W    = 32,
  parameter int    L    = K_ROUNDS,
  parameter string INIT = "../mems/k_constants.memh"
) (
  input  logic                 clk,
  input  logic [$clog2(L)-1:0] addr,
  output logic [W-1:0]         data
);
  // contents are built in; an empty INIT name gives a blank ROM
  localparam bit LOADED = INIT != "";
  always_ff @(posedge clk)
    data <= LOADED ? W'(K_TABLE[addr]) : '0;
endmodule

// File: rtl/k_rom_sequencer.sv
// k_rom_sequencer: streams K[0..L-1] from the ROM through a 4-entry prefetch FIFO
module k_rom_sequencer
  import sha256_pkg::*;
#(
  parameter int    W    = 32,
  parameter int    L    = K_ROUNDS,
  parameter string INIT = "../mems/k_constants.memh"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 k_valid,
  input  logic                 k_ready,
  output logic [W-1:0]         k_data,
  output logic [$clog2(L)-1:0] k_index
);
  localparam int AW = $clog2(L);
  localparam int CW = $clog2(L + 1);
  kseq_state_t state, state_nxt;
  logic [CW-1:0] iss;
  logic [2:0] credits, occ;
  logic [1:0] wptr, rptr;
  logic tag, issue, pop, last_pop, kill, enter;
  logic [W-1:0] rom_data;
  logic [W-1:0] buf_mem [KBUF_DEPTH];
  block_rom #(.W(W), .L(L), .INIT(INIT)) u_rom (
    .clk  (clk),
    .addr (iss[AW-1:0]),
    .data (rom_data)
  );
  assign pop = k_valid && k_ready;
  assign last_pop = pop && k_index == AW'(L - 1);
  assign kill = state == KSEQ_STREAM && abort;
  assign enter = state == KSEQ_IDLE && state_nxt == KSEQ_STREAM;
  assign k_valid = occ != 3'd0;
  assign k_data = buf_mem[rptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= KSEQ_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == KSEQ_IDLE ? ((start && !abort) ? KSEQ_STREAM : KSEQ_IDLE)
                                   : ((abort || last_pop) ? KSEQ_IDLE : KSEQ_STREAM);
  always_comb begin
    busy = state == KSEQ_STREAM;
    issue = busy && iss < CW'(L) && credits < 3'(KBUF_DEPTH);
  end
  // a killed read keeps its ROM data out of the FIFO by dropping its tag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      iss <= '0;
      credits <= '0;
      occ <= '0;
      wptr <= '0;
      rptr <= '0;
      tag <= 1'b0;
      done <= 1'b0;
      k_index <= '0;
      buf_mem <= '{default: '0};
    end else if (kill) begin
      iss <= '0;
      credits <= '0;
      occ <= '0;
      wptr <= '0;
      rptr <= '0;
      tag <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last_pop;
      tag <= issue;
      credits <= credits + {2'b0, issue} - {2'b0, pop};
      occ <= occ + {2'b0, tag} - {2'b0, pop};
      if (issue) iss <= iss + CW'(1);
      if (tag) begin
        buf_mem[wptr] <= rom_data;
        wptr <= wptr + 2'd1;
      end
      if (pop) begin
        rptr <= rptr + 2'd1;
        k_index <= k_index + AW'(1);
      end
      if (enter) begin
        iss <= '0;
        credits <= '0;
        k_index <= '0;
      end
    end
endmodule

// File: tb/tb_k_rom_sequencer.sv
// tb_k_rom_sequencer: random-stimulus bench against a queue-level model of the constant stream
module tb_k_rom_sequencer;
  localparam int L = 64;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, k_ready = 1'b0;
  logic busy, done, k_valid;
  logic [31:0] k_data;
  logic [5:0] k_index;
  int vectors = 0, miscompares = 0;
  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  int m_fifo [$];
  int m_tag = -1, m_issued = 0, m_pops = 0;
  bit m_stream = 1'b0, m_done = 1'b0, chk_en = 1'b0;

  always #5 clk = ~clk;

  k_rom_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .k_valid (k_valid),
    .k_ready (k_ready),
    .k_data  (k_data),
    .k_index (k_index)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // model: round indices flow issue -> in-flight (one cycle) -> FIFO queue -> pop
  always @(posedge clk or negedge rst_n) begin
    bit pop, iss_now, was;
    if (!rst_n) begin
      m_fifo.delete();
      m_tag = -1;
      m_issued = 0;
      m_pops = 0;
      m_stream = 1'b0;
      m_done = 1'b0;
    end else begin
      pop = m_fifo.size() > 0 && k_ready;
      iss_now = m_stream && m_issued < L && (m_fifo.size() + (m_tag >= 0 ? 1 : 0)) < 4;
      was = m_stream;
      m_done = 1'b0;
      if (was && abort) begin
        m_stream = 1'b0;
        m_fifo.delete();
        m_tag = -1;
      end else begin
        if (pop) begin
          void'(m_fifo.pop_front());
          m_pops++;
          if (m_pops == L) begin
            m_done = 1'b1;
            m_stream = 1'b0;
          end
        end
        if (m_tag >= 0) m_fifo.push_back(m_tag);
        if (iss_now) begin
          m_tag = m_issued;
          m_issued++;
        end else m_tag = -1;
        if (!was && start && !abort) begin
          m_stream = 1'b1;
          m_issued = 0;
          m_pops = 0;
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("busy", 32'(busy), 32'(m_stream));
    chk("done", 32'(done), 32'(m_done));
    chk("k_valid", 32'(k_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      chk("k_data", k_data, kt[m_fifo[0]]);
      chk("k_index", 32'(k_index), 32'(m_fifo[0]));
    end
    chk("credits", 32'(dut.credits), 32'(m_fifo.size() + (m_tag >= 0 ? 1 : 0)));
  end

  task automatic run_pass(input bit rnd, input int pulse_at);
    int n = 0;
    bit first = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && n < 2000) begin
      k_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (first && k_valid) begin
        chk("first_word", k_data, 32'h428a2f98);
        first = 1'b0;
      end
      if (pulse_at >= 0 && k_valid && int'(k_index) == pulse_at) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    chk("pass_done", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(k_valid), 32'd0);
    chk("rst_data", k_data, 32'd0);
    chk("rst_index", 32'(k_index), 32'd0);
    k_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 68; c++) begin
      #3;
      if (c == 1) chk("c1_busy", 32'(busy), 32'd1);
      if (c == 3) begin
        chk("c3_valid", 32'(k_valid), 32'd1);
        chk("c3_k0", k_data, 32'h428a2f98);
        chk("c3_idx", 32'(k_index), 32'd0);
      end
      if (c == 66) begin
        chk("c66_k63", k_data, 32'hc67178f2);
        chk("c66_idx", 32'(k_index), 32'd63);
      end
      if (c == 67) begin
        chk("c67_done", 32'(done), 32'd1);
        chk("c67_busy", 32'(busy), 32'd0);
      end
      if (c == 68) chk("c68_done", 32'(done), 32'd0);
      tick();
    end
    run_pass(1'b1, -1);
    run_pass(1'b1, 30);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    chk("idle_start_abort", 32'(busy), 32'd0);
    k_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    #3;
    chk("stall_valid", 32'(k_valid), 32'd1);
    chk("stall_k0", k_data, 32'h428a2f98);
    chk("stall_issued", 32'(m_issued), 32'd4);
    chk("stall_credits", 32'(dut.credits), 32'd4);
    tick();
    k_ready = 1'b1;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("stall_done", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(k_valid && k_index == 6'd10) && n < 100) begin
      tick();
      n++;
    end
    chk("abort_at10", 32'(k_index), 32'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #3;
    chk("abort_valid", 32'(k_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    run_pass(1'b1, -1);
    k_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(k_valid), 32'd0);
    chk("arst_data", k_data, 32'd0);
    chk("arst_index", 32'(k_index), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_pass(1'b1, -1);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/k_rom_sequencer.md
# k_rom_sequencer

Streams the 64 SHA-256 round constants K[0..63] from an internal synchronous `block_rom` to the compression core over a valid/ready interface. It sits between the constants ROM and the round datapath. It hides the ROM's one-cycle read latency behind a 4-entry prefetch buffer, so the core receives one constant per cycle while `k_ready` is held high. One `start` produces exactly one pass of L words, terminated by a `done` pulse; `abort` cancels a pass cleanly.

## Interface
- `W`, default 32: constant width, passed to the ROM.
- `L`, default 64: number of constants per pass, passed to the ROM.
- `INIT`, default "../mems/k_constants.memh": ROM init file, passed to the ROM.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a pass; sampled only in IDLE.
- `abort`  in  1: cancel the current pass; sampled in every state.
- `busy`  out  1: high in STREAM.
- `done`  out  1: one-cycle pulse after the last word is accepted.
- `k_valid`  out  1: buffer head holds a valid constant.
- `k_ready`  in  1: consumer accepts the head this cycle.
- `k_data`  out  W: constant at the buffer head.
- `k_index`  out  $clog2(L): round index of `k_data`.

## Operation
- FSM with two states:
  - IDLE → STREAM on `start && !abort`.
  - STREAM → IDLE when the L-th pop occurs, or on `abort`.
- `done` is registered. It is 1 for exactly the cycle after the L-th pop and is never asserted on abort.
- Issue counter `iss` (0..L):
  - In STREAM, issue ROM address `iss` when `iss < L` and `credits < 4`.
  - Each issue increments `iss` and `credits`.
- `credits` = buffer occupancy + reads outstanding; it is decremented on every pop (`k_valid && k_ready`).
  - Issue and pop in the same cycle leave `credits` unchanged.
  - `credits` never exceeds 4, so the buffer can never overflow.
- Read pipeline:
  - An address issued in cycle n is captured by the ROM at the end of cycle n.
  - A 1-bit tag marks a read as live; the tag is delayed to cycle n+1.
  - Data is written into the buffer at the end of cycle n+1 if the tag is still live.
- Buffer: 4-entry in-order FIFO with 2-bit read and write pointers that wrap 3→0.
  - `k_data` is the head entry.
  - `k_valid` = occupancy ≠ 0.
- `k_index` is a pop counter. It is cleared on entry to STREAM and increments on each pop.
- `abort` in STREAM, at the next edge:
  - clears FIFO pointers, occupancy, `credits` and `iss`;
  - kills outstanding read tags, so late ROM data is discarded;
  - returns to IDLE.
- `abort` in IDLE has no effect. `start` and `abort` high together: `abort` wins.
- `start` in STREAM is ignored; no restart and no queuing.
- `k_ready` while `k_valid` = 0 has no effect.

## Timing
- Reset values: state IDLE; `busy` 0, `done` 0, `k_valid` 0, `k_index` 0, `k_data` 0.
- Reset also clears: `iss`, `credits`, pointers, occupancy, read tags and FIFO storage.
- Reset mid-pass gives the same state as power-up; no `done` pulse.
- `start` high in cycle 0 gives:
  - `busy` high from cycle 1;
  - address 0 issued in cycle 1;
  - `k_valid` high in cycle 3 with `k_data` = K[0] and `k_index` = 0.
- With `k_ready` held at 1: one word per cycle, K[i] in cycle 3+i, last pop in cycle 66, `done` in cycle 67.
- In the `done` cycle, `busy` = 0 and a new `start` is accepted.
- Under backpressure, `k_data` and `k_index` hold stable while `k_valid && !k_ready`.
- Issue stalls after 4 credits; it resumes in the cycle after a pop.
- No combinational path from `k_ready` to `k_valid` or `k_data`.

## Structure
- Shared package `sha256_pkg` holds:
  - the constants `K_ROUNDS` = 64 and `KBUF_DEPTH` = 4;
  - the state enum `kseq_state_t` {KSEQ_IDLE, KSEQ_STREAM}.
- One sub-module: an instance of the existing `block_rom`, with `W`, `L` and `INIT` forwarded.
- The FIFO, credit counter and FSM are inline.

## Test plan
- Reset, then `start` with `k_ready` = 1 → 64 words, K[0] = 0x428a2f98 in cycle 3, K[63] = 0xc67178f2 in cycle 66, `k_index` 0..63 in order, one `done` in cycle 67.
- Random `k_ready` (50%) → same 64 values in order, no duplicates or drops, `k_data` stable while stalled, credit-derived occupancy ≤ 4 throughout.
- Hold `k_ready` = 0 for 20 cycles after `start` → exactly 4 reads issued, `k_valid` = 1 with K[0]; release → stream completes correctly.
- `abort` at `k_index` = 10, with 2 reads outstanding → IDLE next cycle, `k_valid` 0, no `done`; a following `start` delivers K[0] first with no stale word.
- `start` pulsed at `k_index` = 30, and `start` with `abort` in IDLE → pass unaffected and no pass started, respectively.
- `rst_n` low for 1 cycle mid-pass → all outputs 0 immediately (asynchronous); next `start` gives the full correct 64-word pass.
